// File: rtl/program_loader_pkg.sv
// ============================================================================
//  program_loader_pkg
//  State encodings and opcode constants shared by the program loader.
//  Revision: 1.0
// ============================================================================
`include "isa_defines.sv"
`default_nettype none

package program_loader_pkg;

  localparam int         c_STATE_W   = 3;
  localparam logic [2:0] c_S_IDLE    = 3'd0;
  localparam logic [2:0] c_S_COLLECT = 3'd1;
  localparam logic [2:0] c_S_WRITE   = 3'd2;
  localparam logic [2:0] c_S_DONE    = 3'd3;
  localparam logic [2:0] c_S_ERR     = 3'd4;

  localparam logic [4:0] c_OP_NOP = `NOP;
  localparam logic [4:0] c_OP_ST  = `ST;
  localparam logic [4:0] c_OP_JMP = `JMP;
  localparam logic [4:0] c_OP_RST = `RST;

endpackage

`default_nettype wire

// File: rtl/isa_defines.sv
// ============================================================================
//  isa_defines
//  Shared opcode encodings for the instruction-word format (loader/decoder).
//  Revision: 1.0
// ============================================================================
`ifndef ISA_DEFINES_SV
`define ISA_DEFINES_SV

`define NOP 5'h00
`define ST  5'h01
`define JMP 5'h02
`define RST 5'h1F

`endif

// File: rtl/program_loader_word_assembler.sv
// ============================================================================
//  program_loader_word_assembler
//  Shifts bytes in from the LSB end and counts bytes within one word.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module program_loader_word_assembler #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_shift_en,
  input  logic             i_clear,
  input  logic [7:0]       i_byte,
  output logic [WIDTH-1:0] o_word,
  output logic             o_last_byte
);

  localparam int c_BPW = WIDTH / 8;
  localparam int c_CW  = (c_BPW > 1) ? $clog2(c_BPW) : 1;

  logic [WIDTH-1:0] r_word;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] w_shifted;

  generate
    if (c_BPW == 1) begin : g_single
      assign w_shifted = i_byte;
    end else begin : g_multi
      assign w_shifted = {r_word[WIDTH-9:0], i_byte};
    end
  endgenerate

  assign o_last_byte = (r_cnt == c_CW'(c_BPW - 1));
  assign o_word      = r_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_shift_en) begin
      r_word <= w_shifted;
      r_cnt  <= o_last_byte ? '0 : r_cnt + c_CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
//  program_loader
//  Packs a byte stream into instruction words and writes them to program memory.
//  Revision: 1.0
// ============================================================================
`include "isa_defines.sv"
`default_nettype none

module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH    = 5,
  parameter int UNDEFINED     = 3,
  parameter int DATA_WIDTH    = 16,
  parameter int REG_BIT_CNT   = 3,
  parameter int CNTR_WIDTH    = 8,
  parameter int COMBINED_DATA = ADDR_WIDTH + UNDEFINED + DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [7:0]               i_byte_in,
  input  logic                     i_byte_valid,
  output logic                     o_byte_ready,
  output logic [CNTR_WIDTH-1:0]    o_mem_addr,
  output logic [COMBINED_DATA-1:0] o_mem_data,
  output logic                     o_mem_we,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err,
  output logic [CNTR_WIDTH:0]      o_word_count
);

  localparam int c_OP_LSB = UNDEFINED + DATA_WIDTH;
  // A misconfigured instance refuses every word rather than writing garbage.
  localparam bit c_CFG_OK = (COMBINED_DATA % 8 == 0) && (REG_BIT_CNT <= DATA_WIDTH) &&
                            (COMBINED_DATA == ADDR_WIDTH + UNDEFINED + DATA_WIDTH);

  logic [c_STATE_W-1:0]     r_state;
  logic [c_STATE_W-1:0]     w_next;
  logic [CNTR_WIDTH-1:0]    r_addr;
  logic [CNTR_WIDTH:0]      r_wc;
  logic [COMBINED_DATA-1:0] w_word;
  logic                     w_last_byte;
  logic                     w_shift_en;
  logic                     w_start_ok;
  logic                     w_write_ok;
  logic                     w_is_rst;
  logic [ADDR_WIDTH-1:0]    w_opcode;
  logic [UNDEFINED-1:0]     w_pad;

  assign w_opcode   = w_word[COMBINED_DATA-1 -: ADDR_WIDTH];
  assign w_pad      = w_word[c_OP_LSB-1 -: UNDEFINED];
  assign w_is_rst   = (w_opcode == ADDR_WIDTH'(c_OP_RST));
  assign w_write_ok = (w_pad == '0) && c_CFG_OK;
  assign w_shift_en = i_byte_valid && (r_state == c_S_COLLECT);
  assign w_start_ok = i_start && ((r_state == c_S_IDLE) || (r_state == c_S_DONE) ||
                                  (r_state == c_S_ERR));

  program_loader_word_assembler #(
    .WIDTH(COMBINED_DATA)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .i_shift_en (w_shift_en),
    .i_clear    (w_start_ok || (r_state == c_S_WRITE)),
    .i_byte     (i_byte_in),
    .o_word     (w_word),
    .o_last_byte(w_last_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE, c_S_DONE, c_S_ERR: if (i_start) w_next = c_S_COLLECT;
      c_S_COLLECT: if (w_shift_en && w_last_byte) w_next = c_S_WRITE;
      c_S_WRITE: begin
        if (!w_write_ok)         w_next = c_S_ERR;
        else if (w_is_rst)       w_next = c_S_DONE;
        else if (r_addr == '1)   w_next = c_S_ERR;
        else                     w_next = c_S_COLLECT;
      end
      default: w_next = c_S_IDLE;
    endcase
  end

  always_comb begin
    o_byte_ready = 1'b0;
    o_busy       = 1'b0;
    o_mem_we     = 1'b0;
    o_done       = 1'b0;
    o_err        = 1'b0;
    case (r_state)
      c_S_COLLECT: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
      end
      c_S_WRITE: begin
        o_busy   = 1'b1;
        o_mem_we = w_write_ok;
      end
      c_S_DONE: o_done = 1'b1;
      c_S_ERR:  o_err  = 1'b1;
      default: ;
    endcase
  end

  // The address only advances when another word is expected after this one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_wc   <= '0;
    end else if (w_start_ok) begin
      r_addr <= '0;
      r_wc   <= '0;
    end else if ((r_state == c_S_WRITE) && w_write_ok) begin
      r_wc <= r_wc + (CNTR_WIDTH+1)'(1);
      if (!w_is_rst && (r_addr != '1)) r_addr <= r_addr + CNTR_WIDTH'(1);
    end
  end

  assign o_mem_addr   = r_addr;
  assign o_mem_data   = w_word;
  assign o_word_count = r_wc;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
//  tb_program_loader
//  Randomized stimulus against a word-level reference model of the loader.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_program_loader;
  import program_loader_pkg::*;

  localparam int CW  = 8;
  localparam int CD  = 24;
  localparam int BPW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready, mem_we, busy, done, err;
  logic [CW-1:0] mem_addr;
  logic [CD-1:0] mem_data;
  logic [CW:0]   word_count;

  program_loader dut (
    .clk(clk), .rst(rst), .i_start(start), .i_byte_in(byte_in), .i_byte_valid(byte_valid),
    .o_byte_ready(byte_ready), .o_mem_addr(mem_addr), .o_mem_data(mem_data), .o_mem_we(mem_we),
    .o_busy(busy), .o_done(done), .o_err(err), .o_word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a load is "in progress" from start until its terminating word.
  logic          m_load = 1'b0, m_wnow = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [CD-1:0] m_cur  = '0;
  logic [CW-1:0] m_addr = '0;
  logic [CW:0]   m_wc   = '0;
  int            m_nb   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_load <= 1'b0; m_wnow <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      m_cur <= '0; m_addr <= '0; m_wc <= '0; m_nb <= 0;
    end else if (m_wnow) begin
      m_wnow <= 1'b0;
      if (m_cur[18:16] != 3'b000) begin
        m_load <= 1'b0; m_err <= 1'b1;
      end else begin
        m_wc <= m_wc + 1;
        if (m_cur[23:19] == c_OP_RST) begin
          m_load <= 1'b0; m_done <= 1'b1;
        end else if (m_addr == 8'd255) begin
          m_load <= 1'b0; m_err <= 1'b1;
        end else begin
          m_addr <= m_addr + 1;
        end
      end
    end else if (!m_load && start) begin
      m_load <= 1'b1; m_done <= 1'b0; m_err <= 1'b0;
      m_addr <= '0; m_wc <= '0; m_nb <= 0;
    end else if (m_load && byte_valid) begin
      m_cur <= {m_cur[CD-9:0], byte_in};
      if (m_nb == BPW - 1) begin
        m_nb <= 0; m_wnow <= 1'b1;
      end else begin
        m_nb <= m_nb + 1;
      end
    end
  end

  logic [CW+CD-1:0] q_log[$];
  logic [CW+CD-1:0] q_exp[$];
  bit               e_done, e_err;
  int               e_wc;

  always @(negedge clk) begin
    chk("byte_ready", 32'(byte_ready), 32'(m_load && !m_wnow));
    chk("busy",       32'(busy),       32'(m_load));
    chk("mem_we",     32'(mem_we),     32'(m_wnow && (m_cur[18:16] == 3'b000)));
    chk("mem_addr",   32'(mem_addr),   32'(m_addr));
    if (m_wnow && (m_cur[18:16] == 3'b000)) chk("mem_data", 32'(mem_data), 32'(m_cur));
    chk("done",       32'(done),       32'(m_done));
    chk("err",        32'(err),        32'(m_err));
    chk("word_count", 32'(word_count), 32'(m_wc));
    chk("done_err_excl", 32'(done && err), 32'd0);
    if (mem_we === 1'b1) q_log.push_back({mem_addr, mem_data});
  end

  // Writes a program must produce, derived straight from the termination rules.
  task automatic build_expected(input logic [CD-1:0] prog[$]);
    q_exp.delete(); e_done = 1'b0; e_err = 1'b0;
    for (int i = 0; i < prog.size(); i++) begin
      if (prog[i][18:16] != 3'b000) begin e_err = 1'b1; break; end
      q_exp.push_back({i[CW-1:0], prog[i]});
      if (prog[i][23:19] == c_OP_RST) begin e_done = 1'b1; break; end
      if (i == 255) begin e_err = 1'b1; break; end
    end
    e_wc = q_exp.size();
  endtask

  task automatic check_log(input string nm);
    chk({nm, "_nwrites"}, 32'(q_log.size()), 32'(q_exp.size()));
    for (int i = 0; i < q_exp.size() && i < q_log.size(); i++) begin
      chk({nm, "_waddr"}, 32'(q_log[i][CW+CD-1:CD]), 32'(q_exp[i][CW+CD-1:CD]));
      chk({nm, "_wdata"}, 32'(q_log[i][CD-1:0]),     32'(q_exp[i][CD-1:0]));
    end
    chk({nm, "_done"},  32'(done),       32'(e_done));
    chk({nm, "_err"},   32'(err),        32'(e_err));
    chk({nm, "_count"}, 32'(word_count), 32'(e_wc));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd, input bit sp, output bit ok);
    bit acc;
    int tries;
    acc = 1'b0; tries = 0; ok = 1'b1;
    while (!acc) begin
      @(negedge clk);
      if (!m_load) begin
        byte_valid = 1'b0; start = 1'b0; ok = 1'b0;
        return;
      end
      byte_in    = b;
      byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start      = sp ? ($urandom_range(0, 3) == 0) : 1'b0;
      acc        = byte_valid && m_load && !m_wnow;
      tries++;
      if (!acc && tries > 64) begin
        n_vec++; n_miss++;
        $display("FAIL byte_timeout: byte %0h not accepted within 64 cycles", b);
        ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1; byte_valid = 1'b1; byte_in = 8'hEE;
  endtask

  task automatic send_prog(input logic [CD-1:0] prog[$], input bit rnd, input bit sp);
    bit ok;
    ok = 1'b1;
    for (int w = 0; w < prog.size() && ok; w++) begin
      for (int k = 0; k < BPW && ok; k++) begin
        send_byte(prog[w][CD-1-8*k -: 8], rnd, sp, ok);
      end
    end
    repeat (4) begin
      @(negedge clk);
      start = 1'b0; byte_valid = 1'($urandom_range(0, 1)); byte_in = 8'($urandom);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  initial begin
    logic [CD-1:0] prog[$];
    bit ok;

    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_count", 32'(word_count), 32'd0);
    rst = 1'b0;

    // Single-word program, byte_valid held high
    q_log.delete();
    prog = '{ {c_OP_RST, 3'b000, 16'h0000} };
    build_expected(prog);
    do_start();
    send_prog(prog, 1'b0, 1'b0);
    check_log("t1");
    chk("t1_lit_data", 32'(q_log[0][CD-1:0]), 32'h00F80000);
    chk("t1_lit_count", 32'(word_count), 32'd1);

    // Three-word program with random byte_valid gaps
    q_log.delete();
    prog = '{ {c_OP_ST, 3'b000, 16'hA5A5}, {c_OP_JMP, 3'b000, 16'h0002}, {c_OP_RST, 3'b000, 16'h0000} };
    build_expected(prog);
    do_start();
    send_prog(prog, 1'b1, 1'b0);
    check_log("t2");
    chk("t2_lit_w0", 32'(q_log[0][CD-1:0]), 32'h0008A5A5);
    chk("t2_lit_w1", 32'(q_log[1]), 32'h01100002);
    chk("t2_lit_count", 32'(word_count), 32'd3);

    // Pad violation on the second word
    q_log.delete();
    prog = '{ {c_OP_ST, 3'b000, 16'h1234}, {c_OP_JMP, 3'b101, 16'h0002}, {c_OP_RST, 3'b000, 16'h0000} };
    build_expected(prog);
    do_start();
    send_prog(prog, 1'b1, 1'b0);
    check_log("t3");
    chk("t3_lit_err", 32'(err), 32'd1);
    chk("t3_lit_count", 32'(word_count), 32'd1);
    chk("t3_lit_ready", 32'(byte_ready), 32'd0);

    // Memory overflow: 256 NOPs, no terminating word
    q_log.delete();
    prog.delete();
    for (int i = 0; i < 256; i++) prog.push_back({c_OP_NOP, 3'b000, 16'($urandom)});
    build_expected(prog);
    do_start();
    send_prog(prog, 1'b1, 1'b0);
    check_log("t4");
    chk("t4_lit_count", 32'(word_count), 32'd256);
    chk("t4_lit_lastaddr", 32'(q_log[255][CW+CD-1:CD]), 32'd255);

    // Asynchronous reset in the middle of a word
    q_log.delete();
    do_start();
    send_byte(8'hF8, 1'b0, 1'b0, ok);
    send_byte(8'h00, 1'b0, 1'b0, ok);
    @(negedge clk);
    byte_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_async_busy",  32'(busy),       32'd0);
    chk("t5_async_ready", 32'(byte_ready), 32'd0);
    chk("t5_async_we",    32'(mem_we),     32'd0);
    chk("t5_async_addr",  32'(mem_addr),   32'd0);
    chk("t5_async_data",  32'(mem_data),   32'd0);
    chk("t5_async_count", 32'(word_count), 32'd0);
    chk("t5_async_flags", 32'({done, err}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      byte_valid = 1'($urandom_range(0, 1)); byte_in = 8'($urandom);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    chk("t5_no_write", 32'(q_log.size()), 32'd0);
    prog = '{ {c_OP_RST, 3'b000, 16'h1234} };
    build_expected(prog);
    do_start();
    send_prog(prog, 1'b0, 1'b0);
    check_log("t5");

    // Restart from DONE with start pulses during collection
    q_log.delete();
    prog = '{ {c_OP_ST, 3'b000, 16'hBEEF}, {c_OP_NOP, 3'b000, 16'h0F0F}, {c_OP_RST, 3'b000, 16'h0001} };
    build_expected(prog);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6_done_clr", 32'(done), 32'd0);
    chk("t6_busy", 32'(busy), 32'd1);
    send_prog(prog, 1'b1, 1'b1);
    check_log("t6");
    chk("t6_lit_addr2", 32'(q_log[2][CW+CD-1:CD]), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    n_miss++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
